// File: rtl/uart_rx_if.sv
// Receiver-side bundle: the serial line in, the received byte and status pulses out.
`timescale 1ns/1ps
interface uart_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       rx_valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   modport master (output rx, input data, rx_valid, frame_err, parity_err, busy);
   modport slave  (input rx, output data, rx_valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver; define UART_RX_PARITY_EN for 8E1 frames with even-parity checking.
// Holds the last good byte and pulses rx_valid / frame_err / parity_err for one cycle.
`timescale 1ns/1ps
module uart_rx #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115_200
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.slave  bus
);
   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned HALF         = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

   if (CLKS_PER_BIT < 4) begin : g_cfg_check
      $error("uart_rx: CLK_FREQ / BAUD must be at least 4");
   end

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   state_t           state, state_d;
   logic             rx_meta, rx_s;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [2:0]       idx, idx_d;
   logic [7:0]       shift, shift_d;
   logic [7:0]       data_q, data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             parity_err_q, parity_err_d;
   logic             busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic             par, par_d;
`endif

   // Two-flop synchronizer; idle-high reset so a reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         shift        <= '0;
         data_q       <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par          <= 1'b0;
`endif
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         idx          <= idx_d;
         shift        <= shift_d;
         data_q       <= data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
         par          <= par_d;
`endif
      end
   end

   // Next-state and registered-output logic; the counter clears on every sample point.
   always_comb begin
      state_d      = state;
      cnt_d        = cnt + CNT_W'(1);
      idx_d        = idx;
      shift_d      = shift;
      data_d       = data_q;
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d        = par;
`endif
      unique case (state)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = START;
               idx_d   = '0;
`ifdef UART_RX_PARITY_EN
               par_d   = 1'b0;
`endif
            end
         end
         START: begin
            if (cnt == CNT_HALF) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift[7:1]};
               idx_d   = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
               par_d   = par ^ rx_s;
               if (idx == 3'd7) state_d = PARITY;
`else
               if (idx == 3'd7) state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == CNT_LAST) begin
               cnt_d   = '0;
               par_d   = par ^ rx_s;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_d = '0;
               // A low stop bit outranks a parity mismatch.
               if (!rx_s) begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
`ifdef UART_RX_PARITY_EN
               end else if (par) begin
                  parity_err_d = 1'b1;
                  state_d      = IDLE;
`endif
               end else begin
                  data_d     = shift;
                  rx_valid_d = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign bus.data       = data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.parity_err = parity_err_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_CLKS = 16;
`else
   localparam int PAR_CLKS = 0;
`endif
   localparam int LATENCY   = 2 + 8 + 144 + PAR_CLKS;
   localparam int BUSY_CYCS = LATENCY - 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_rx_if bus ();

   uart_rx #(.CLK_FREQ(160), .BAUD(10)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int         cyc = 0;
   int         n_valid = 0, n_ferr = 0, n_perr = 0, n_busy = 0;
   int         last_valid_cyc = 0;
   logic [7:0] dq[$];
   int         n_checks = 0, n_fail = 0;
   int         first_low = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.rx_valid) begin
         n_valid        = n_valid + 1;
         last_valid_cyc = cyc;
         dq.push_back(bus.data);
      end
      if (bus.frame_err)  n_ferr = n_ferr + 1;
      if (bus.parity_err) n_perr = n_perr + 1;
      if (bus.busy)       n_busy = n_busy + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one frame from a falling edge; the stop level is held hold_low extra clocks.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input logic par_flip, input int hold_low);
      logic pbit;
      pbit      = (^d) ^ par_flip;
      bus.rx    = 1'b0;
      first_low = cyc + 1;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = d[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      bus.rx = pbit;
      repeat (BIT_CLKS) @(negedge clk);
`endif
      bus.rx = stop_bit;
      repeat (BIT_CLKS + hold_low) @(negedge clk);
      bus.rx = 1'b1;
   endtask

   typedef struct {
      logic [7:0] din;
      logic       stop_bit;
      logic       par_flip;
      int         hold_low;
      int         exp_valid;
      int         exp_ferr;
      int         exp_perr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int v0, f0, p0, b0, q0;
      vecs.push_back('{8'h5A, 1'b1, 1'b0, 0,  1, 0, 0, 8'h5A});
      vecs.push_back('{8'h01, 1'b1, 1'b0, 0,  1, 0, 0, 8'h01});
      vecs.push_back('{8'h80, 1'b1, 1'b0, 0,  1, 0, 0, 8'h80});
      vecs.push_back('{8'h55, 1'b0, 1'b0, 40, 0, 1, 0, 8'h80});
      vecs.push_back('{8'h12, 1'b1, 1'b0, 0,  1, 0, 0, 8'h12});
`ifdef UART_RX_PARITY_EN
      vecs.push_back('{8'h07, 1'b1, 1'b0, 0,  1, 0, 0, 8'h07});
      vecs.push_back('{8'h07, 1'b1, 1'b1, 0,  0, 0, 1, 8'h07});
`endif

      bus.rx = 1'b1;
      rst    = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_data",  32'(bus.data), 32'h00);
      check("reset_valid", 32'(bus.rx_valid), 32'd0);
      check("reset_ferr",  32'(bus.frame_err), 32'd0);
      check("reset_perr",  32'(bus.parity_err), 32'd0);
      check("reset_busy",  32'(bus.busy), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Single byte with exact latency and busy duration.
      v0 = n_valid; f0 = n_ferr; p0 = n_perr; b0 = n_busy;
      send_frame(8'hA5, 1'b1, 1'b0, 0);
      repeat (4) @(negedge clk);
      check("single_valid_cnt", 32'(n_valid - v0), 32'd1);
      check("single_latency",   32'(last_valid_cyc - first_low), 32'(LATENCY));
      check("single_data",      32'(bus.data), 32'hA5);
      check("single_busy_cycs", 32'(n_busy - b0), 32'(BUSY_CYCS));
      check("single_no_err",    32'((n_ferr - f0) + (n_perr - p0)), 32'd0);

      // Start-bit glitch of 5 clocks.
      v0 = n_valid; f0 = n_ferr; p0 = n_perr; b0 = n_busy;
      bus.rx = 1'b0;
      repeat (5) @(negedge clk);
      bus.rx = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);
      check("glitch_busy_cycs", 32'(n_busy - b0), 32'd8);
      check("glitch_busy_low",  32'(bus.busy), 32'd0);
      check("glitch_data",      32'(bus.data), 32'hA5);

      foreach (vecs[k]) begin
         v0 = n_valid; f0 = n_ferr; p0 = n_perr;
         send_frame(vecs[k].din, vecs[k].stop_bit, vecs[k].par_flip, 0);
         if (vecs[k].hold_low > 0) begin
            bus.rx = 1'b0;
            repeat (vecs[k].hold_low) @(negedge clk);
            check($sformatf("vec%0d_busy_in_break", k), 32'(bus.busy), 32'd1);
            bus.rx = 1'b1;
         end
         repeat (6) @(negedge clk);
         check($sformatf("vec%0d_valid", k), 32'(n_valid - v0), 32'(vecs[k].exp_valid));
         check($sformatf("vec%0d_ferr", k),  32'(n_ferr - f0),  32'(vecs[k].exp_ferr));
         check($sformatf("vec%0d_perr", k),  32'(n_perr - p0),  32'(vecs[k].exp_perr));
         check($sformatf("vec%0d_data", k),  32'(bus.data),     32'(vecs[k].exp_data));
         check($sformatf("vec%0d_idle", k),  32'(bus.busy),     32'd0);
      end

      // Reset in the middle of data bit 4.
      bus.rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.rx = 1'(i % 2);
         repeat (BIT_CLKS) @(negedge clk);
      end
      bus.rx = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_data",  32'(bus.data), 32'h00);
      check("async_rst_busy",  32'(bus.busy), 32'd0);
      check("async_rst_valid", 32'(bus.rx_valid | bus.frame_err | bus.parity_err), 32'd0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      v0 = n_valid; f0 = n_ferr; p0 = n_perr;
      repeat (60) @(negedge clk);
      check("post_rst_pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);
      send_frame(8'h81, 1'b1, 1'b0, 0);
      repeat (4) @(negedge clk);
      check("post_rst_valid", 32'(n_valid - v0), 32'd1);
      check("post_rst_data",  32'(bus.data), 32'h81);

      // Three frames with no idle gap.
      v0 = n_valid; q0 = dq.size();
      send_frame(8'h3C, 1'b1, 1'b0, 0);
      send_frame(8'hFF, 1'b1, 1'b0, 0);
      send_frame(8'h00, 1'b1, 1'b0, 0);
      repeat (4) @(negedge clk);
      check("b2b_valid_cnt", 32'(n_valid - v0), 32'd3);
      if (dq.size() >= q0 + 3) begin
         check("b2b_byte0", 32'(dq[q0]),     32'h3C);
         check("b2b_byte1", 32'(dq[q0 + 1]), 32'hFF);
         check("b2b_byte2", 32'(dq[q0 + 2]), 32'h00);
      end else begin
         check("b2b_queue_len", 32'(dq.size() - q0), 32'd3);
      end
      check("b2b_idle", 32'(bus.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for 8N1 frames (optionally 8E1) at a fixed baud rate derived from the system clock. Sits directly upstream of the seven-segment display driver. Holds the last correctly received byte on `data[7:0]`, which feeds the display's 8-bit data input, and issues a one-cycle strobe per received byte for other consumers.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer division). `HALF = CLKS_PER_BIT / 2`. `CLKS_PER_BIT` must be ≥ 4; elaboration fails otherwise.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `data`  out  8  last good byte, held until the next good frame.
- `rx_valid`  out  1  one-cycle pulse when `data` updates.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- A bit counter runs with width `$clog2(CLKS_PER_BIT)`, alongside a 3-bit data index and an 8-bit shift register.
- States:
  - **IDLE**: on `rx_s == 0`, clear the counter and go to START.
  - **START**: count. At counter == HALF−1, sample `rx_s`. If 1, the start was false: go to IDLE with no error pulse. If 0, clear the counter and go to DATA.
  - **DATA**: sample at counter == CLKS_PER_BIT−1. Shift in LSB first. After the 8th sample, go to PARITY (if compiled in) or STOP.
  - **PARITY**: sample at counter == CLKS_PER_BIT−1, then go to STOP.
  - **STOP**: sample at counter == CLKS_PER_BIT−1.
    - If the sample is 1 and parity is OK: load `data` from the shift register, pulse `rx_valid`, go to IDLE.
    - If the sample is 0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
    - If the sample is 1 and parity is bad: pulse `parity_err`, leave `data` unchanged, go to IDLE.
  - **BREAK**: wait for `rx_s == 1`, then go to IDLE. This prevents a held-low line from retriggering frames.
- A frame with both a stop error and a parity error pulses `frame_err` only.
- The counter clears on every sample. Sample spacing is exactly CLKS_PER_BIT clocks.
- The block returns to IDLE at mid-stop-bit, so back-to-back frames with a single stop bit are received without loss.

## Timing
- Reset values: `data` = 8'h00, `rx_valid` = 0, `frame_err` = 0, `parity_err` = 0, `busy` = 0, state IDLE. Reset mid-frame aborts the frame immediately with no pulses.
- Outputs are registered. `data` and `rx_valid` change on the same edge, the edge that takes the stop sample.
- Latency is measured from the first `clk` edge at which `rx` is registered low (the first synchronizer flop). The stop-sample edge follows it after 2 + HALF + 9·CLKS_PER_BIT clocks, plus CLKS_PER_BIT with parity.
- `busy` rises one edge after IDLE detects `rx_s == 0`. It falls on the edge that returns the block to IDLE.
- Pulses last exactly one cycle. No more than one pulse type fires per frame.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present and expects even parity (XOR of the 8 data bits and the parity bit is 0).
  - `parity_err` is live.
  - The frame is 11 bits.
- Not defined:
  - No PARITY state; DATA goes straight to STOP.
  - `parity_err` is tied to 0.
  - The frame is 10 bits.

## Test plan
All scenarios use `CLK_FREQ=160`, `BAUD=10` (CLKS_PER_BIT=16, HALF=8).
- **Single byte**: after reset, send 8'hA5 as 8N1. Required: `rx_valid` pulses once, exactly 2+8+144 clocks after the first registered low. `data` = 8'hA5, `busy` is high for the frame, and no error pulses occur.
- **Back-to-back**: send 8'h3C, 8'hFF, 8'h00 with no idle gap. Required: three `rx_valid` pulses, with `data` sequencing 3C, FF, 00.
- **Glitch rejection**: drive `rx` low for 5 clocks, then high. Required: START aborts at HALF, no pulses, `data` unchanged, `busy` back to 0.
- **Framing error**: send 8'h55 with the stop bit 0 and hold the line low for 40 more clocks. Required: one `frame_err` pulse, `data` keeps its previous value, and the block stays in BREAK until `rx` goes high. A following 8'h12 is then received correctly.
- **Reset mid-frame**: assert `rst` during bit 4 of a frame. Required: all outputs are 0 asynchronously, with no pulses after release. The next full frame, 8'h81, is received.
- **Parity** (`UART_RX_PARITY_EN`): send 8'h07 with parity bit 1. Required: `rx_valid`, `data` = 8'h07. Resend with parity bit 0. Required: `parity_err` pulse, `data` still 8'h07.
